sha2_msg_pad: RTL and testbench
===============================

Name: sha2_msg_pad

Overview:
Message-padding stage between the HMAC control core and the SHA-256 compression engine. It takes the core's word stream (32-bit data plus 4-bit byte mask) and the message bit length. It emits the FIPS 180-4 padded stream to the compression engine one 32-bit word per handshake: message words, the 0x80 terminator merged into the final word, zero fill to 448 mod 512, then the 64-bit length. It runs in both plain-SHA and HMAC modes, since the core's outputs feed it in either mode.

Parameters:
BlockSize, 512, SHA-256 block size in bits; fixed, not overridable.
LenPos, 448, bit offset within a block where the length field starts.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous, active-low
sha_en  input  1  engine enable; 0 forces StIdle and clears counters
hash_start  input  1  pulse; begin a new message
hash_process  input  1  pulse; message fully written, begin padding
message_length  input  64  message length in bits (multiple of 8)
in_rvalid  input  1  upstream word valid
in_rdata  input  36  {data[35:4], mask[3:0]}; byte 0 = data[31:24]
in_rready  output  1  upstream word accepted
shaf_rvalid  output  1  padded word valid
shaf_rdata  output  32  padded word
shaf_rready  input  1  compression engine accepts word
pad_done  output  1  one-cycle pulse when the last length word is accepted
err_o  output  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset values: state=StIdle, tx_count=0, msg_len_q=0, process_flag=0. All outputs are 0 during and after reset.
- tx_count[63:0] advances +32 on each shaf_rvalid&&shaf_rready. It is cleared by hash_start.
- msg_len_q latches message_length on the hash_process cycle. process_flag is set by hash_process and cleared by hash_start or pad_done.
- hash_start in any state clears tx_count/process_flag and moves to StFifoReceive. This aborts the current message with no further output; hash_start has priority over every other event.
- States:
  - StIdle: no output. On hash_start (sha_en=1), go to StFifoReceive.
  - StFifoReceive: shaf_rvalid=in_rvalid, shaf_rdata=in_rdata data, in_rready=in_rvalid&&shaf_rready.
    - If process_flag && tx_count+32 > msg_len_q, go to StPad80. This is evaluated before passthrough; that cycle outputs nothing (one bubble).
    - Words arriving in the hash_process cycle itself pass through normally.
  - StPad80: r = msg_len_q[4:3].
    - r=0: emit 0x8000_0000 unconditionally; in_rready=0.
    - r!=0: wait for in_rvalid, then emit the data bytes 0..r-1 kept, byte r = 0x80, remaining bytes 0. in_rready = shaf_rready.
    - Once the word is accepted: if the new tx_count[8:0]==448, go to StLenHi; else go to StPad00.
  - StPad00: emit 0 until the accepted word makes tx_count[8:0]==448, then go to StLenHi.
  - StLenHi: emit msg_len_q[63:32], then go to StLenLo.
  - StLenLo: emit msg_len_q[31:0]. On accept, pulse pad_done and go to StIdle.
- Block wrap: if the terminator word lands at 448..479 mod 512, zero fill runs through the next block. The message then occupies an extra full block.
- The output may stall indefinitely (shaf_rready=0); shaf_rdata is held stable while valid.
- sha_en=0 mid-message: return to StIdle immediately; no pad_done.
- The length compare is unsigned 64-bit; overflow of tx_count+32 is not supported.

Optional Feature:
Macro SHA2_MSG_PAD_CHECK_EN.
- Defined: err_o is set sticky (cleared only by reset or hash_start) on either of:
  - a word accepted in StFifoReceive with mask != 4'hF;
  - the StPad80 merge word whose mask is not the r contiguous upper bytes (e.g. r=2 requires 4'b1100).
- Not defined: err_o is tied 0 and there is no checker logic.

Decomposition:
- Shared package hmac_pkg holds:
  - sha_fifo_t {data[31:0], mask[3:0]};
  - the pad state enum (StIdle, StFifoReceive, StPad80, StPad00, StLenHi, StLenLo);
  - BlockSize and LenPos.
- One natural combinational sub-module, sha2_pad_merge: (data, r) -> terminator word.

Test Plan:
- "abc" (msg_len=24; word 0x6162_63xx, mask 4'b1110): outputs are 0x6162_6380, then 13×0, then 0x0000_0000, 0x0000_0018. pad_done fires on word 16; err_o=0.
- Empty message (hash_start then hash_process, msg_len=0): outputs 0x8000_0000, 13×0, 0, 0; 16 words total.
- 56-byte message (14 full words, msg_len=448): 14 data words, 0x8000_0000, 15×0, 0, 0x1C0; 32 words and pad_done once.
- 64-byte message with shaf_rready toggled randomly: data is stable under stall, the 32-word sequence matches the reference model, and in_rready never rises while shaf_rready=0.
- hash_start at word 5 of the padding phase: the stream aborts and a new 3-byte message then pads correctly. Also assert rst_ni mid-StPad00: all outputs are 0 and state is StIdle.
- With SHA2_MSG_PAD_CHECK_EN: a mask 4'b1000 word in mid-message sets err_o=1, which holds until hash_start.

Source files
------------

// File: rtl/hmac_pkg.sv
// Shared types for the HMAC/SHA-256 datapath: upstream word format, padder
// state encoding and the SHA-256 block geometry.
package hmac_pkg;

  localparam int unsigned BlockSize = 512;
  localparam int unsigned LenPos    = 448;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } sha_fifo_t;

  typedef enum logic [2:0] {
    StIdle,
    StFifoReceive,
    StPad80,
    StPad00,
    StLenHi,
    StLenLo
  } pad_st_e;

  // Byte mask a final partial word must carry: the r leading bytes valid.
  function automatic logic [3:0] pad_tail_mask(input logic [1:0] r);
    logic [3:0] m;
    case (r)
      2'd1:    m = 4'b1000;
      2'd2:    m = 4'b1100;
      2'd3:    m = 4'b1110;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sha2_pad_merge.sv
// Builds the terminator word: the first r message bytes of the final partial
// word are kept, byte r becomes 0x80 and the remaining bytes are zeroed.
module sha2_pad_merge (
  input  logic [31:0] data_i,
  input  logic [1:0]  r_i,
  output logic [31:0] word_o
);

  // Byte 0 is the most significant byte of the word.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(r_i)) begin
        word_o[31-8*k -: 8] = data_i[31-8*k -: 8];
      end else if (k == int'(r_i)) begin
        word_o[31-8*k -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha2_msg_pad.sv
// SHA-256 message padder: message words, 0x80 terminator, zero fill, 64-bit length.
// Optional sticky mask checker is built when SHA2_MSG_PAD_CHECK_EN is defined.
module sha2_msg_pad
  import hmac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sha_en,
  input  logic        hash_start,
  input  logic        hash_process,
  input  logic [63:0] message_length,
  input  logic        in_rvalid,
  input  logic [35:0] in_rdata,
  output logic        in_rready,
  output logic        shaf_rvalid,
  output logic [31:0] shaf_rdata,
  input  logic        shaf_rready,
  output logic        pad_done,
  output logic        err_o,
  output pad_st_e     dbg_state_o
);

  // Handshakes: a word moves when valid && ready are both high at a rising
  // clock edge. Once valid is raised, the producer holds data until taken.

  localparam int unsigned     BlkBits   = $clog2(BlockSize);
  localparam logic [BlkBits-1:0] LenPosMod = BlkBits'(LenPos);

  sha_fifo_t   in_word;
  pad_st_e     state_q, state_d;
  logic [63:0] tx_count_q, tx_count_d;
  logic [63:0] msg_len_q, msg_len_d;
  logic        process_flag_q, process_flag_d;
  logic [63:0] tx_next;
  logic        len_hit;
  logic [1:0]  pad_r;
  logic [31:0] merge_word;
  logic        fifo_take;
  logic        merge_take;

  assign in_word     = in_rdata;
  assign pad_r       = msg_len_q[4:3];
  assign dbg_state_o = state_q;

  sha2_pad_merge u_merge (
    .data_i (in_word.data),
    .r_i    (pad_r),
    .word_o (merge_word)
  );

  always_comb begin
    state_d        = state_q;
    tx_count_d     = tx_count_q;
    msg_len_d      = msg_len_q;
    process_flag_d = process_flag_q;
    shaf_rvalid    = 1'b0;
    shaf_rdata     = '0;
    in_rready      = 1'b0;
    pad_done       = 1'b0;
    fifo_take      = 1'b0;
    merge_take     = 1'b0;
    tx_next        = tx_count_q + 64'd32;
    len_hit        = (tx_next[BlkBits-1:0] == LenPosMod);

    if (hash_process) begin
      msg_len_d      = message_length;
      process_flag_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
      end

      StFifoReceive: begin
        // The final partial word is not passed through; it is merged in StPad80.
        if (process_flag_q && (tx_next > msg_len_q)) begin
          state_d = StPad80;
        end else begin
          shaf_rvalid = in_rvalid;
          shaf_rdata  = in_word.data;
          in_rready   = in_rvalid && shaf_rready;
          fifo_take   = in_rvalid && shaf_rready;
        end
      end

      StPad80: begin
        if (pad_r == 2'd0) begin
          shaf_rvalid = 1'b1;
          shaf_rdata  = 32'h8000_0000;
        end else begin
          shaf_rvalid = in_rvalid;
          shaf_rdata  = merge_word;
          in_rready   = shaf_rready;
          merge_take  = in_rvalid && shaf_rready;
        end
        if (shaf_rvalid && shaf_rready) begin
          state_d = len_hit ? StLenHi : StPad00;
        end
      end

      StPad00: begin
        shaf_rvalid = 1'b1;
        if (shaf_rready && len_hit) begin
          state_d = StLenHi;
        end
      end

      StLenHi: begin
        shaf_rvalid = 1'b1;
        shaf_rdata  = msg_len_q[63:32];
        if (shaf_rready) begin
          state_d = StLenLo;
        end
      end

      StLenLo: begin
        shaf_rvalid = 1'b1;
        shaf_rdata  = msg_len_q[31:0];
        if (shaf_rready) begin
          pad_done       = 1'b1;
          process_flag_d = 1'b0;
          state_d        = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (shaf_rvalid && shaf_rready) begin
      tx_count_d = tx_next;
    end

    // hash_start aborts whatever is in flight, then the enable gates everything.
    if (hash_start) begin
      state_d        = StFifoReceive;
      tx_count_d     = '0;
      process_flag_d = 1'b0;
      shaf_rvalid    = 1'b0;
      shaf_rdata     = '0;
      in_rready      = 1'b0;
      pad_done       = 1'b0;
      fifo_take      = 1'b0;
      merge_take     = 1'b0;
    end

    if (!sha_en) begin
      state_d        = StIdle;
      tx_count_d     = '0;
      process_flag_d = 1'b0;
      shaf_rvalid    = 1'b0;
      shaf_rdata     = '0;
      in_rready      = 1'b0;
      pad_done       = 1'b0;
      fifo_take      = 1'b0;
      merge_take     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      tx_count_q     <= '0;
      msg_len_q      <= '0;
      process_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_count_q     <= tx_count_d;
      msg_len_q      <= msg_len_d;
      process_flag_q <= process_flag_d;
    end
  end

`ifdef SHA2_MSG_PAD_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (fifo_take && (in_word.mask != 4'hF)) begin
      err_d = 1'b1;
    end
    if (merge_take && (in_word.mask != pad_tail_mask(pad_r))) begin
      err_d = 1'b1;
    end
    if (hash_start) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{in_word.mask, fifo_take, merge_take};
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_sha2_msg_pad.sv
// Bench for sha2_msg_pad: random messages against a byte-level FIPS 180-4 padding model.
module tb_sha2_msg_pad;
  import hmac_pkg::*;

`ifdef SHA2_MSG_PAD_CHECK_EN
  localparam logic ChkEn = 1'b1;
`else
  localparam logic ChkEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sha_en = 1'b0;
  logic        hash_start = 1'b0;
  logic        hash_process = 1'b0;
  logic [63:0] message_length = '0;
  logic        in_rvalid = 1'b0;
  logic [35:0] in_rdata = '0;
  logic        in_rready;
  logic        shaf_rvalid;
  logic [31:0] shaf_rdata;
  logic        shaf_rready = 1'b0;
  logic        pad_done;
  logic        err_o;
  pad_st_e     dbg_state;

  sha2_msg_pad dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sha_en         (sha_en),
    .hash_start     (hash_start),
    .hash_process   (hash_process),
    .message_length (message_length),
    .in_rvalid      (in_rvalid),
    .in_rdata       (in_rdata),
    .in_rready      (in_rready),
    .shaf_rvalid    (shaf_rvalid),
    .shaf_rdata     (shaf_rdata),
    .shaf_rready    (shaf_rready),
    .pad_done       (pad_done),
    .err_o          (err_o),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  msg[$];
  int          out_words = 0;
  int          pad_cnt = 0;
  bit          rdy_rand = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: pad the byte string, then cut it into big-endian words.
  task automatic model_expected(input int nbytes);
    logic [7:0]  p[$];
    logic [63:0] bits;
    bits = 64'(nbytes) * 64'd8;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    for (int w = 0; w < p.size() / 4; w++)
      exp_q.push_back({p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    logic [31:0] w;
    if (shaf_rvalid && prev_stall) check_eq("stall_hold", 64'(shaf_rdata), 64'(prev_data));
    if (!shaf_rready) check_eq("in_rready_gated", 64'(in_rready), 64'd0);
    if (shaf_rvalid && shaf_rready) begin
      out_words++;
      if (exp_q.size() == 0) begin
        check_eq("word_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        w = exp_q.pop_front();
        check_eq("word", 64'(shaf_rdata), 64'(w));
        check_eq("pad_done_last", 64'(pad_done), 64'(exp_q.size() == 0));
      end
    end else if (pad_done) begin
      check_eq("pad_done_stray", 64'(pad_done), 64'd0);
    end
    if (pad_done) pad_cnt++;
    prev_stall = shaf_rvalid && !shaf_rready;
    prev_data  = shaf_rdata;
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      shaf_rready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_hash_start();
    hash_start = 1'b1;
    next_cycle();
    hash_start = 1'b0;
  endtask

  task automatic do_hash_process(input logic [63:0] len);
    message_length = len;
    hash_process   = 1'b1;
    next_cycle();
    hash_process   = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] m);
    int n;
    n = 0;
    in_rvalid = 1'b1;
    in_rdata  = {d, m};
    forever begin
      @(negedge clk_i);
      if (in_rready) break;
      n++;
      if (n > 300) begin
        check_eq("in_accept", 64'(in_rready), 64'd1);
        break;
      end
    end
    next_cycle();
    in_rvalid = 1'b0;
  endtask

  task automatic fill_random(input int nbytes);
    msg.delete();
    for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
  endtask

  // Streams msg: full words, then hash_process, then the partial tail word.
  task automatic start_msg(input int bad_word);
    int          nbytes, nfull, rem;
    logic [31:0] d;
    logic [3:0]  m;
    nbytes = msg.size();
    nfull  = nbytes / 4;
    rem    = nbytes % 4;
    model_expected(nbytes);
    out_words = 0;
    do_hash_start();
    for (int w = 0; w < nfull; w++) begin
      d = {msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]};
      m = (w == bad_word) ? 4'b1000 : 4'hF;
      push_word(d, m);
      repeat ($urandom_range(0, 2)) next_cycle();
    end
    do_hash_process(64'(nbytes) * 64'd8);
    if (rem != 0) begin
      d = $urandom;
      for (int k = 0; k < rem; k++) d[31-8*k -: 8] = msg[4*nfull+k];
      m = 4'hF;
      m = m << (4 - rem);
      push_word(d, m);
    end
  endtask

  task automatic wait_done(input int exp_words, input logic exp_err);
    int base, n;
    base = pad_cnt;
    n = 0;
    while (pad_cnt == base && n < 3000) begin
      next_cycle();
      n++;
    end
    repeat (3) next_cycle();
    check_eq("pad_done_count", 64'(pad_cnt - base), 64'd1);
    check_eq("word_count", 64'(out_words), 64'(exp_words));
    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check_eq("err_o", 64'(err_o), 64'(exp_err));
    check_eq("state_idle", 64'(dbg_state), 64'(StIdle));
  endtask

  task automatic wait_words(input int n);
    int c;
    c = 0;
    while (out_words < n && c < 500) begin
      next_cycle();
      c++;
    end
    check_eq("words_reached", 64'(out_words >= n), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk_i);
    check_eq({tag, "_rvalid"}, 64'(shaf_rvalid), 64'd0);
    check_eq({tag, "_rdata"}, 64'(shaf_rdata), 64'd0);
    check_eq({tag, "_in_rready"}, 64'(in_rready), 64'd0);
    check_eq({tag, "_pad_done"}, 64'(pad_done), 64'd0);
    check_eq({tag, "_err"}, 64'(err_o), 64'd0);
    check_eq({tag, "_state"}, 64'(dbg_state), 64'(StIdle));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, len;
    repeat (3) @(posedge clk_i);
    check_quiet("in_reset");
    next_cycle();
    rst_ni = 1'b1;
    sha_en = 1'b1;
    repeat (2) next_cycle();
    check_quiet("after_reset");
    next_cycle();

    // "abc"
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    start_msg(-1);
    wait_done(16, 1'b0);

    // empty message
    msg.delete();
    start_msg(-1);
    wait_done(16, 1'b0);

    // 56 bytes: terminator lands at 448, zero fill spills into a second block
    fill_random(56);
    start_msg(-1);
    wait_done(32, 1'b0);

    // 64 bytes with random backpressure
    rdy_rand = 1'b1;
    fill_random(64);
    start_msg(-1);
    wait_done(32, 1'b0);

    // random lengths
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 140);
      fill_random(len);
      start_msg(-1);
      wait_done(((len + 8) / 64 + 1) * 16, 1'b0);
    end
    rdy_rand = 1'b0;

    // abort five words into the padding phase, then a fresh 3-byte message
    fill_random(8);
    start_msg(-1);
    wait_words(7);
    exp_q.delete();
    do_hash_start();
    @(negedge clk_i);
    check_eq("abort_state", 64'(dbg_state), 64'(StFifoReceive));
    check_eq("abort_rvalid", 64'(shaf_rvalid), 64'd0);
    repeat (5) next_cycle();
    fill_random(3);
    start_msg(-1);
    wait_done(16, 1'b0);

    // asynchronous reset in the middle of zero fill
    msg.delete();
    start_msg(-1);
    wait_words(3);
    rst_ni = 1'b0;
    exp_q.delete();
    check_quiet("mid_reset");
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
    check_quiet("post_mid_reset");
    next_cycle();
    fill_random(5);
    start_msg(-1);
    wait_done(16, 1'b0);

    // enable drop mid-padding: back to idle, no pad_done
    fill_random(20);
    start_msg(-1);
    wait_words(6);
    base = pad_cnt;
    sha_en = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check_eq("en_drop_rvalid", 64'(shaf_rvalid), 64'd0);
    repeat (10) next_cycle();
    @(negedge clk_i);
    check_eq("en_drop_state", 64'(dbg_state), 64'(StIdle));
    check_eq("en_drop_no_done", 64'(pad_cnt - base), 64'd0);
    next_cycle();
    sha_en = 1'b1;
    next_cycle();

    // bad mask on a mid-message word
    fill_random(12);
    start_msg(1);
    wait_done(16, ChkEn);
    do_hash_start();
    @(negedge clk_i);
    check_eq("err_cleared", 64'(err_o), 64'd0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
